// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// Latency: none (wires only).
// Backpressure: the master holds req/we/addr/wdata until the slave pulses ack.
interface mem_access_stage_if #(
   parameter int DATA_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores over a req/ack bus and registers the MEM/WB bundle.
// Latency: 1 falling edge for non-memory ops; 3 edges for a zero-wait access, +1 per wait cycle.
// Backpressure: StallM freezes EX/MEM and upstream while an access is pending; W gets bubbles.
module mem_access_stage #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RegWriteM,
   input  logic              MemtoRegM,
   input  logic              MemWriteM,
   input  logic              FlagsWriteM,
   input  logic [DATA_W-1:0] ALUOutM,
   input  logic [DATA_W-1:0] WriteDataM,
   input  logic [3:0]        WA3M,
   input  logic [3:0]        ALUFlagsM,
   mem_access_stage_if.master mem,
   output logic              StallM,
   output logic              mem_err,
   output logic              RegWriteW,
   output logic              MemtoRegW,
   output logic              FlagsWriteW,
   output logic [DATA_W-1:0] ReadDataW,
   output logic [DATA_W-1:0] ALUOutW,
   output logic [3:0]        WA3W,
   output logic [3:0]        ALUFlagsW
);
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_cap_q, rdata_cap_d;
   logic              abort_q, abort_d;
   logic              err_q, err_d;
   logic              regwrite_w_q, regwrite_w_d;
   logic              memtoreg_w_q, memtoreg_w_d;
   logic              flagswrite_w_q, flagswrite_w_d;
   logic [DATA_W-1:0] readdata_w_q, readdata_w_d;
   logic [DATA_W-1:0] aluout_w_q, aluout_w_d;
   logic [3:0]        wa3_w_q, wa3_w_d;
   logic [3:0]        flags_w_q, flags_w_d;

   logic memop, mis;

   assign memop = MemWriteM | MemtoRegM;
   assign mis   = memop & (ALUOutM[1:0] != 2'b00);

   // Stall is gated by rst so a reset in mid-access releases the pipeline at once.
   assign StallM = ~rst & (((state_q == S_IDLE) & memop & ~mis) | (state_q == S_ACCESS));

   // Next-state logic: W controls default to a bubble, W data and bus signals default to hold.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      req_d          = req_q;
      we_d           = we_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      rdata_cap_d    = rdata_cap_q;
      abort_d        = abort_q;
      err_d          = err_q;
      regwrite_w_d   = 1'b0;
      memtoreg_w_d   = 1'b0;
      flagswrite_w_d = 1'b0;
      readdata_w_d   = readdata_w_q;
      aluout_w_d     = aluout_w_q;
      wa3_w_d        = wa3_w_q;
      flags_w_d      = flags_w_q;

      case (state_q)
         S_IDLE: begin
            if (!memop) begin
               regwrite_w_d   = RegWriteM;
               memtoreg_w_d   = 1'b0;
               flagswrite_w_d = FlagsWriteM;
               readdata_w_d   = '0;
               aluout_w_d     = ALUOutM;
               wa3_w_d        = WA3M;
               flags_w_d      = ALUFlagsM;
            end else if (mis) begin
               err_d = 1'b1;
            end else begin
               state_d = S_ACCESS;
               req_d   = 1'b1;
               we_d    = MemWriteM;
               addr_d  = {ALUOutM[DATA_W-1:2], 2'b00};
               wdata_d = WriteDataM;
               cnt_d   = '0;
            end
         end
         S_ACCESS: begin
            // An ack on the final allowed cycle completes normally rather than aborting.
            if (mem.mem_ack) begin
               if (!we_q) rdata_cap_d = mem.mem_rdata;
               req_d   = 1'b0;
               state_d = S_DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               req_d   = 1'b0;
               abort_d = 1'b1;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (abort_q) begin
               abort_d = 1'b0;
            end else begin
               // Load+store together behaves as a store: no memory result to write back.
               regwrite_w_d   = RegWriteM;
               memtoreg_w_d   = MemtoRegM & ~MemWriteM;
               flagswrite_w_d = FlagsWriteM;
               readdata_w_d   = MemWriteM ? '0 : rdata_cap_q;
               aluout_w_d     = ALUOutM;
               wa3_w_d        = WA3M;
               flags_w_d      = ALUFlagsM;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers update on the falling edge, matching the pipeline segment registers.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         req_q          <= 1'b0;
         we_q           <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         rdata_cap_q    <= '0;
         abort_q        <= 1'b0;
         err_q          <= 1'b0;
         regwrite_w_q   <= 1'b0;
         memtoreg_w_q   <= 1'b0;
         flagswrite_w_q <= 1'b0;
         readdata_w_q   <= '0;
         aluout_w_q     <= '0;
         wa3_w_q        <= '0;
         flags_w_q      <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         req_q          <= req_d;
         we_q           <= we_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         rdata_cap_q    <= rdata_cap_d;
         abort_q        <= abort_d;
         err_q          <= err_d;
         regwrite_w_q   <= regwrite_w_d;
         memtoreg_w_q   <= memtoreg_w_d;
         flagswrite_w_q <= flagswrite_w_d;
         readdata_w_q   <= readdata_w_d;
         aluout_w_q     <= aluout_w_d;
         wa3_w_q        <= wa3_w_d;
         flags_w_q      <= flags_w_d;
      end
   end

   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign mem_err       = err_q;
   assign RegWriteW     = regwrite_w_q;
   assign MemtoRegW     = memtoreg_w_q;
   assign FlagsWriteW   = flagswrite_w_q;
   assign ReadDataW     = readdata_w_q;
   assign ALUOutW       = aluout_w_q;
   assign WA3W          = wa3_w_q;
   assign ALUFlagsW     = flags_w_q;
endmodule
